// File: rtl/led_frame_serializer.sv
// Latches a set of NUM_LEDS packed LED frames and presents them one bit per
// bit_rqst to the LED bit-timing encoder, flagging frame and set boundaries.
module led_frame_serializer #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned BITS_PER_LED = 24,
  parameter bit          MSB_FIRST    = 1'b1,
  localparam int unsigned LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  localparam int unsigned BW = $clog2(BITS_PER_LED)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic [NUM_LEDS*BITS_PER_LED-1:0] frames_in,
  input  logic                             bit_rqst,
  output logic                             bit_to_transmit,
  output logic                             bit_valid,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             set_done,
  output logic [LW-1:0]                    led_idx,
  output logic [BW-1:0]                    bit_idx
);

  localparam int unsigned TOTAL = NUM_LEDS * BITS_PER_LED;
  localparam int unsigned SW    = $clog2(TOTAL);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                r_state,   w_state_nxt;
  logic [TOTAL-1:0]      r_shadow,  w_shadow_nxt;
  logic [LW-1:0]         r_led_idx, w_led_idx_nxt;
  logic [BW-1:0]         r_bit_idx, w_bit_idx_nxt;
  logic                  r_frame_done, w_frame_done_nxt;
  logic                  r_set_done,   w_set_done_nxt;

  logic [SW-1:0]           w_base;
  logic [BITS_PER_LED-1:0] w_frame;
  logic [BW-1:0]           w_pos;
  logic                    w_last_bit;
  logic                    w_last_led;

  // Bit selection from the shadow copy; the shadow is the only data source once a set runs.
  assign w_base  = SW'(r_led_idx) * SW'(BITS_PER_LED);
  assign w_frame = r_shadow[w_base +: BITS_PER_LED];
  assign w_pos   = MSB_FIRST ? (BW'(BITS_PER_LED - 1) - r_bit_idx) : r_bit_idx;

  assign w_last_bit = (r_bit_idx == BW'(BITS_PER_LED - 1));
  assign w_last_led = (r_led_idx == LW'(NUM_LEDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shadow     <= '0;
      r_led_idx    <= '0;
      r_bit_idx    <= '0;
      r_frame_done <= 1'b0;
      r_set_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shadow     <= w_shadow_nxt;
      r_led_idx    <= w_led_idx_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_set_done   <= w_set_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_shadow_nxt     = r_shadow;
    w_led_idx_nxt    = r_led_idx;
    w_bit_idx_nxt    = r_bit_idx;
    w_frame_done_nxt = 1'b0;
    w_set_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        // abort beats start so a simultaneous pair leaves the block idle
        if (start && !abort) begin
          w_shadow_nxt  = frames_in;
          w_led_idx_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          w_state_nxt   = IDLE;
          w_led_idx_nxt = '0;
          w_bit_idx_nxt = '0;
        end else if (bit_rqst) begin
          if (!w_last_bit) begin
            w_bit_idx_nxt = r_bit_idx + BW'(1);
          end else if (!w_last_led) begin
            w_bit_idx_nxt    = '0;
            w_led_idx_nxt    = r_led_idx + LW'(1);
            w_frame_done_nxt = 1'b1;
          end else begin
            w_bit_idx_nxt    = '0;
            w_led_idx_nxt    = '0;
            w_frame_done_nxt = 1'b1;
            w_set_done_nxt   = 1'b1;
            w_state_nxt      = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy            = (r_state == SHIFT);
  assign bit_valid       = (r_state == SHIFT);
  assign bit_to_transmit = (r_state == SHIFT) & w_frame[w_pos];
  assign frame_done      = r_frame_done;
  assign set_done        = r_set_done;
  assign led_idx         = r_led_idx;
  assign bit_idx         = r_bit_idx;

endmodule

// File: tb/tb_led_frame_serializer.sv
// Self-checking bench: default-parameter instance checked every cycle against a
// count-based reference model, plus a directed LSB-first 2x32 instance.
module tb_led_frame_serializer;

  localparam int unsigned NL  = 8;
  localparam int unsigned BPL = 24;
  localparam int unsigned TOT = NL * BPL;

  logic clk;
  logic rst, start, abort, bit_rqst;
  logic [TOT-1:0] frames;
  logic bit_tx, bit_valid, busy, frame_done, set_done;
  logic [2:0] led_idx;
  logic [4:0] bit_idx;

  logic b_rst, b_start, b_abort, b_rqst;
  logic [63:0] b_frames;
  logic b_bit, b_valid, b_busy, b_fd, b_sd;
  logic [0:0] b_led_idx;
  logic [4:0] b_bit_idx;

  int n_pass  = 0;
  int n_total = 0;
  int cnt_fd  = 0;
  int cnt_sd  = 0;

  // Reference model: a set is just a list of bits in send order and a count consumed.
  bit m_busy = 0;
  int m_n    = 0;
  bit m_fd   = 0;
  bit m_sd   = 0;
  bit m_bits [TOT];

  led_frame_serializer #(.NUM_LEDS(NL), .BITS_PER_LED(BPL), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frames_in(frames),
    .bit_rqst(bit_rqst), .bit_to_transmit(bit_tx), .bit_valid(bit_valid), .busy(busy),
    .frame_done(frame_done), .set_done(set_done), .led_idx(led_idx), .bit_idx(bit_idx)
  );

  led_frame_serializer #(.NUM_LEDS(2), .BITS_PER_LED(32), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort), .frames_in(b_frames),
    .bit_rqst(b_rqst), .bit_to_transmit(b_bit), .bit_valid(b_valid), .busy(b_busy),
    .frame_done(b_fd), .set_done(b_sd), .led_idx(b_led_idx), .bit_idx(b_bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic randomize_frames();
    for (int i = 0; i < TOT / 32; i++) frames[i*32 +: 32] = $urandom();
  endtask

  // Apply one cycle of inputs, advance the model at the edge, then compare.
  task automatic cyc(input logic s, input logic a, input logic r, input logic rs);
    start = s; abort = a; bit_rqst = r; rst = rs;
    @(posedge clk);
    m_fd = 0;
    m_sd = 0;
    if (rs) begin
      m_busy = 0;
      m_n    = 0;
    end else if (!m_busy) begin
      if (s && !a) begin
        m_busy = 1;
        m_n    = 0;
        for (int k = 0; k < NL; k++)
          for (int j = 0; j < BPL; j++)
            m_bits[k*BPL + j] = frames[k*BPL + (BPL - 1 - j)];
      end
    end else if (a) begin
      m_busy = 0;
      m_n    = 0;
    end else if (r) begin
      m_n++;
      if (m_n % BPL == 0) m_fd = 1;
      if (m_n == TOT) begin
        m_sd   = 1;
        m_busy = 0;
        m_n    = 0;
      end
    end
    #1;
    cnt_fd += int'(frame_done);
    cnt_sd += int'(set_done);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("bit_valid", 32'(bit_valid), 32'(m_busy));
    if (m_busy) chk("bit_to_transmit", 32'(bit_tx), 32'(m_bits[m_n]));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("set_done", 32'(set_done), 32'(m_sd));
    chk("led_idx", 32'(led_idx), 32'(m_n / BPL));
    chk("bit_idx", 32'(bit_idx), 32'(m_n % BPL));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; bit_rqst = 1'b0; frames = '0;
    b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_rqst = 1'b0; b_frames = '0;

    // Reset state
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Known pattern, held request, back-to-back restart
    frames = {24'h222222, 24'hCCCCCC, 24'hAAAAAA, 24'h999999,
              24'h888888, 24'h444444, 24'hBBBBBB, 24'h111111};
    cyc(1, 0, 0, 0);
    cnt_fd = 0; cnt_sd = 0;
    repeat (TOT) cyc(0, 0, 1, 0);
    chk("frame_done_count", 32'(cnt_fd), 32'd8);
    chk("set_done_count", 32'(cnt_sd), 32'd1);

    // Input change and second start mid-set are ignored
    cyc(1, 0, 0, 0);
    cnt_sd = 0;
    repeat (10) cyc(0, 0, 1, 0);
    frames = '1;
    cyc(1, 0, 1, 0);
    repeat (TOT - 11) cyc(0, 0, 1, 0);
    chk("set_done_once", 32'(cnt_sd), 32'd1);
    cyc(0, 0, 0, 0);

    // Sparse requests, every third cycle
    randomize_frames();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3 * TOT; i++) cyc(0, 0, (i % 3 == 2), 0);
    cyc(0, 0, 0, 0);

    // Abort at LED 3 bit 5, coinciding with a request
    randomize_frames();
    cyc(1, 0, 0, 0);
    repeat (3 * BPL + 5) cyc(0, 0, 1, 0);
    chk("abort_point_led", 32'(led_idx), 32'd3);
    chk("abort_point_bit", 32'(bit_idx), 32'd5);
    cnt_sd = 0;
    cyc(0, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk("abort_no_set_done", 32'(cnt_sd), 32'd0);
    randomize_frames();
    cyc(1, 0, 0, 0);
    repeat (5) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);

    // Reset mid-set at LED 6 together with start
    randomize_frames();
    cyc(1, 0, 0, 0);
    repeat (6 * BPL + 4) cyc(0, 0, 1, 0);
    cnt_fd = 0; cnt_sd = 0;
    cyc(1, 0, 1, 1);
    cyc(0, 0, 1, 0);
    chk("rst_no_pulses", 32'(cnt_fd + cnt_sd), 32'd0);

    // Random traffic
    randomize_frames();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) randomize_frames();
      cyc(($urandom_range(7) == 0), ($urandom_range(63) == 0),
          1'($urandom_range(1)), ($urandom_range(255) == 0));
    end

    // LSB-first 2x32 instance
    rst = 1'b0; start = 1'b0; abort = 1'b0; bit_rqst = 1'b0;
    b_frames = {32'h0000_0002, 32'h8000_0001};
    @(posedge clk); #1;
    chk("b_reset_busy", 32'(b_busy), 32'd0);
    chk("b_reset_bit", 32'(b_bit), 32'd0);
    b_rst = 1'b0; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; b_rqst = 1'b1;
    chk("b_busy", 32'(b_busy), 32'd1);
    for (int i = 0; i < 64; i++) begin
      chk("b_bit", 32'(b_bit), 32'(b_frames[i]));
      @(posedge clk); #1;
      chk("b_frame_done", 32'(b_fd), 32'(i % 32 == 31));
      chk("b_set_done", 32'(b_sd), 32'(i == 63));
    end
    b_rqst = 1'b0;
    chk("b_idle_busy", 32'(b_busy), 32'd0);
    chk("b_idle_led", 32'(b_led_idx), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_frame_serializer.md
Name: led_frame_serializer

Overview:
- Parametrised successor to the fixed 8-LED × 24-bit frame transmitter.
- Latches a full frame set (NUM_LEDS frames of BITS_PER_LED bits) from a packed bus into a shadow register, then presents one bit at a time to the LED bit-timing encoder.
- Advances one bit per bit_rqst and flags end of each LED frame and end of set.
- Adds selectable bit order, abort, busy status and immunity to input changes mid-transfer.

Parameters:
- NUM_LEDS, 8, number of LED frames per set (>=1).
- BITS_PER_LED, 24, bits per LED frame (24 for GRB, 32 for GRBW; >=2).
- MSB_FIRST, 1, 1 = bit BITS_PER_LED-1 of each frame sent first; 0 = bit 0 sent first.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to latch frames_in and begin a set; honoured only when busy=0.
- abort  input  1  terminate the current set immediately.
- frames_in  input  NUM_LEDS*BITS_PER_LED  packed frames; LED k occupies bits [k*BITS_PER_LED +: BITS_PER_LED].
- bit_rqst  input  1  consume the currently presented bit and advance.
- bit_to_transmit  output  1  currently presented bit.
- bit_valid  output  1  bit_to_transmit is meaningful.
- busy  output  1  set in progress.
- frame_done  output  1  one-cycle pulse after the last bit of any LED frame is consumed.
- set_done  output  1  one-cycle pulse after the last bit of LED NUM_LEDS-1 is consumed.
- led_idx  output  LW  index of the LED being sent; LW = max(1, clog2(NUM_LEDS)).
- bit_idx  output  BW  bits already consumed in the current frame; BW = clog2(BITS_PER_LED).

Behaviour:
- FSM states: IDLE, SHIFT. All outputs are registered or decoded purely from registers; there is no combinational input-to-output path.
- Reset (rst=1 at an edge): state IDLE; shadow cleared to 0; busy=0, bit_valid=0, bit_to_transmit=0, frame_done=0, set_done=0, led_idx=0, bit_idx=0.
- rst has priority over all other inputs. Reset mid-set discards the set with no frame_done/set_done.
- IDLE:
  - start=1 → at that edge, capture frames_in into shadow, set led_idx=0, bit_idx=0, enter SHIFT.
  - busy=1 and bit_valid=1 from the next cycle, i.e. one cycle of latency after start.
  - bit_rqst in IDLE is ignored.
- SHIFT:
  - bit_to_transmit = shadow bit [led_idx*BITS_PER_LED + p].
  - p = BITS_PER_LED-1-bit_idx when MSB_FIRST=1; p = bit_idx otherwise.
- bit_rqst=1 in SHIFT:
  - bit_idx < BITS_PER_LED-1: bit_idx+1.
  - bit_idx = BITS_PER_LED-1 and led_idx < NUM_LEDS-1: bit_idx=0, led_idx+1, frame_done=1 next cycle.
  - bit_idx = BITS_PER_LED-1 and led_idx = NUM_LEDS-1: frame_done=1 and set_done=1 in the same next cycle; go to IDLE with busy=0, bit_valid=0, led_idx=0, bit_idx=0.
- Held bit_rqst advances one bit per cycle. A full set needs exactly NUM_LEDS*BITS_PER_LED accepted requests.
- start while busy=1 is ignored. It is not queued.
- frames_in changes while busy have no effect on output.
- abort=1 in SHIFT → IDLE next cycle; indices cleared; no frame_done/set_done.
  - If abort and bit_rqst coincide, abort wins and no pulses are generated.
  - abort in IDLE has no effect. abort and start together in IDLE: abort wins, start dropped.
- After set_done, a start in the very next cycle is accepted (back-to-back sets, one idle cycle minimum).
- NUM_LEDS=1: led_idx is constant 0; frame_done and set_done coincide.

Test Plan:
- Default parameters, LED0..7 = 0x111111, 0xBBBBBB, 0x444444, 0x888888, 0x999999, 0xAAAAAA, 0xCCCCCC, 0x222222, start pulse, bit_rqst held high → first four bits 0,0,0,1; frame_done pulses 24 cycles apart (8 total); set_done exactly once after 192 requests; busy falls the same cycle.
- MSB_FIRST=0, NUM_LEDS=2, BITS_PER_LED=32, LED0=0x80000001, LED1=0x00000002 → LED0 sequence 1, then 30× 0, then 1; LED1 sequence 0, 1, then 30× 0; set_done after request 64.
- Start the default set, change frames_in to all-ones after 10 bits, and pulse start again mid-set → output still matches the originally latched data; second start ignored; exactly one set_done.
- Sparse bit_rqst (every 3rd cycle) → bit_idx increments only on request cycles; bit_to_transmit stable between requests.
- abort at led_idx=3, bit_idx=5 → busy=0, bit_valid=0, indices 0 next cycle; no set_done. A following start restarts from LED0 bit 0.
- rst asserted at led_idx=6, then start asserted in the same cycle as rst → all outputs at reset values; start ignored; no pulses.
